// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass and a
// per-register pending-write scoreboard for RAW stall detection.
module regfile_mp_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREG),
    localparam int unsigned CW      = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_err,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] rel;
    logic [NWR-1:0]  wr_ok;
    logic            rsv_ok;
    logic            rsv_hit;
    logic [CW-1:0]   cnt_d;

    // Addresses that name a real, writable/reservable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_ok = '0;
        rel   = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            wr_ok[p] = wr_en[p] && addr_ok(wr_addr[p*AW +: AW]);
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_ok[p] && (32'(wr_addr[p*AW +: AW]) == r)) begin
                    rel[r] = 1'b1;
                end
            end
        end
    end

    // Release first, then reserve, so a simultaneous reserve keeps the bit set.
    always_comb begin
        rsv_ok  = rsv_en && addr_ok(rsv_addr);
        rsv_hit = rsv_ok && busy_q[rsv_addr] && !rel[rsv_addr];
        busy_d  = busy_q & ~rel;
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        cnt_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q   <= '0;
            rsv_err  <= 1'b0;
            busy_cnt <= '0;
        end else begin
            // Later ports override earlier ones on an address collision.
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_ok[p]) begin
                    regs_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
            busy_q   <= busy_d;
            rsv_err  <= rsv_hit;
            busy_cnt <= cnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (!rst && addr_ok(rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                    end
                end
                rd_busy[i] = busy_q[rd_addr[i*AW +: AW]] && !rel[rd_addr[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_regfile_mp_sb;

    localparam int AW = 5;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [63:0]     wr_data;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data;
    logic [1:0]      rd_busy;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_err;
    logic [5:0]      busy_cnt;

    regfile_mp_sb dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_err  (rsv_err),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {KRd0, KRd1, KBusy0, KBusy1, KErr, KCnt} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_val(input string name, input kind_e kind, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor: outputs are settled mid-cycle, after the inputs driven at posedge+1.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                KRd0:    act = rd_data[31:0];
                KRd1:    act = rd_data[63:32];
                KBusy0:  act = 32'(rd_busy[0]);
                KBusy1:  act = 32'(rd_busy[1]);
                KErr:    act = 32'(rsv_err);
                default: act = 32'(busy_cnt);
            endcase
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rsv_en = 1'b0; rsv_addr = '0; rst = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic rsv(input int a);
        rsv_en = 1'b1;
        rsv_addr = AW'(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        rd(0, 5);
        expect_val("rst_rd0", KRd0, 32'h0);

        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            rd(0, a); rd(1, 31 - a);
            expect_val("init_rd0", KRd0, 32'h0);
            expect_val("init_rd1", KRd1, 32'h0);
            expect_val("init_busy0", KBusy0, 32'h0);
            expect_val("init_busy1", KBusy1, 32'h0);
        end
        expect_val("init_cnt", KCnt, 32'h0);
        expect_val("init_err", KErr, 32'h0);

        // 2: bypass then stored value
        next_cycle();
        wr(0, 5, 32'hDEADBEEF); rd(0, 5);
        expect_val("bypass5", KRd0, 32'hDEADBEEF);
        next_cycle();
        rd(0, 5); rd(1, 5);
        expect_val("stored5_p0", KRd0, 32'hDEADBEEF);
        expect_val("stored5_p1", KRd1, 32'hDEADBEEF);

        // 3: write collision, zero register, cross-port bypass
        next_cycle();
        wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
        expect_val("collide_bypass", KRd0, 32'h2222);
        next_cycle();
        rd(0, 7);
        expect_val("collide_stored", KRd0, 32'h2222);
        next_cycle();
        wr(0, 0, 32'hFFFF); rd(0, 0);
        expect_val("zero_bypass", KRd0, 32'h0);
        next_cycle();
        rd(0, 0);
        expect_val("zero_stored", KRd0, 32'h0);
        next_cycle();
        wr(0, 7, 32'h3333); wr(1, 9, 32'h4444); rd(0, 9); rd(1, 7);
        expect_val("xbyp_rd0", KRd0, 32'h4444);
        expect_val("xbyp_rd1", KRd1, 32'h3333);

        // 4: reserve / release of reg 3
        next_cycle();
        rsv(3); rd(0, 3);
        expect_val("rsv3_same_cycle", KBusy0, 32'h0);
        next_cycle();
        rd(0, 3);
        expect_val("rsv3_busy", KBusy0, 32'h1);
        expect_val("rsv3_cnt", KCnt, 32'h1);
        next_cycle();
        wr(1, 3, 32'hAB); rd(0, 3);
        expect_val("rel3_busy", KBusy0, 32'h0);
        expect_val("rel3_data", KRd0, 32'hAB);
        expect_val("rel3_cnt_before", KCnt, 32'h1);
        next_cycle();
        rd(0, 3);
        expect_val("rel3_cnt_after", KCnt, 32'h0);
        expect_val("rel3_busy_after", KBusy0, 32'h0);

        // 5: reserve collides with release, then a real double reserve
        next_cycle();
        rsv(4);
        next_cycle();
        wr(0, 4, 32'h44); rsv(4); rd(0, 4);
        expect_val("r4_released_busy", KBusy0, 32'h0);
        expect_val("r4_cnt", KCnt, 32'h1);
        expect_val("r4_err_first", KErr, 32'h0);
        next_cycle();
        rsv(4); rd(0, 4);
        expect_val("r4_err_rsv_rel", KErr, 32'h0);
        expect_val("r4_still_busy", KBusy0, 32'h1);
        expect_val("r4_cnt_kept", KCnt, 32'h1);
        next_cycle();
        expect_val("r4_err_double", KErr, 32'h1);
        expect_val("r4_cnt_double", KCnt, 32'h1);
        next_cycle();
        rsv(0); rd(0, 0);
        expect_val("r4_err_clears", KErr, 32'h0);
        expect_val("r0_busy", KBusy0, 32'h0);
        next_cycle();
        rd(0, 0);
        expect_val("r0_rsv_no_err", KErr, 32'h0);
        expect_val("r0_rsv_no_cnt", KCnt, 32'h1);
        expect_val("r0_rsv_no_busy", KBusy0, 32'h0);

        // 6: reservations wiped by reset, write during reset dropped
        next_cycle(); rsv(1);
        next_cycle(); rsv(2);
        expect_val("cnt_after_r1", KCnt, 32'h2);
        next_cycle(); rsv(3);
        next_cycle();
        rd(0, 1);
        expect_val("cnt_before_rst", KCnt, 32'h4);
        expect_val("r1_busy_before_rst", KBusy0, 32'h1);
        next_cycle();
        rst = 1'b1; wr(0, 8, 32'h55); rd(0, 5); rd(1, 1);
        expect_val("in_rst_rd0", KRd0, 32'h0);
        expect_val("in_rst_busy1", KBusy1, 32'h0);
        next_cycle();
        rd(0, 5); rd(1, 1);
        expect_val("post_rst_cnt", KCnt, 32'h0);
        expect_val("post_rst_busy1", KBusy1, 32'h0);
        expect_val("post_rst_rd5", KRd0, 32'h0);
        expect_val("post_rst_err", KErr, 32'h0);
        next_cycle();
        rd(0, 8); rd(1, 3);
        expect_val("rst_dropped_wr8", KRd0, 32'h0);
        expect_val("post_rst_busy3", KBusy1, 32'h0);

        next_cycle();
        next_cycle();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
